// File: rtl/gpio_pkg.sv
// Types shared by the input-capture and output/direction sides of the GPIO block.
// Bus width and bus word type seen by the bus-side reader.
package gpio_pkg;

   localparam int GPIO_BUS_W = 32;

   typedef logic [GPIO_BUS_W-1:0] gpio_bus_t;

   // One-cycle edge pulses from a single debounced pin.
   typedef struct packed {
      logic rise;
      logic fall;
   } pin_event_t;

endpackage

// File: rtl/gpio_in_debounce.sv
// One pin: two-flop synchroniser, debounce counter and stable level.
// Emits one-cycle rise/fall pulses on the same edge the stable level changes.
module gpio_in_debounce
   import gpio_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pin,
   output logic       level,
   output pin_event_t evt
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic             stable;
   logic [CNT_W-1:0] cnt;
   logic             differ;
   logic             commit;

   assign differ = sync2 ^ stable;
   assign commit = differ && (cnt == CNT_LAST);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         stable <= 1'b0;
         cnt    <= '0;
      end else begin
         sync1 <= pin;
         sync2 <= sync1;
         if (!differ) begin
            cnt <= '0;
         end else if (commit) begin
            stable <= sync2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   // The committed value is sync2, so its polarity decides rise versus fall.
   assign level    = stable;
   assign evt.rise = commit & sync2;
   assign evt.fall = commit & ~sync2;

endmodule

// File: rtl/gpio_in_capture.sv
// Debounced GPIO input capture: per-pin edge enables, sticky pending bits and
// a registered interrupt, presented zero-extended on 32-bit buses.
module gpio_in_capture
   import gpio_pkg::*;
#(
   parameter int WIDTH_PIN       = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH_PIN-1:0] pin_in,
   input  gpio_bus_t            cfg_rise,
   input  gpio_bus_t            cfg_fall,
   input  logic                 cfg_valid,
   input  gpio_bus_t            clr,
   input  logic                 clr_valid,
   output gpio_bus_t            level_o,
   output gpio_bus_t            pend_o,
   output logic                 irq
);

   logic [WIDTH_PIN-1:0] level;
   logic [WIDTH_PIN-1:0] set;
   logic [WIDTH_PIN-1:0] en_rise;
   logic [WIDTH_PIN-1:0] en_fall;
   logic [WIDTH_PIN-1:0] pend;
   logic [WIDTH_PIN-1:0] pend_nxt;
   logic [WIDTH_PIN-1:0] clr_mask;
   pin_event_t           evt [WIDTH_PIN];
   logic                 unused_bus_bits;

   for (genvar g = 0; g < WIDTH_PIN; g++) begin : g_pin
      gpio_in_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk  (clk),
         .rst_n(rst_n),
         .pin  (pin_in[g]),
         .level(level[g]),
         .evt  (evt[g])
      );

      assign set[g] = (evt[g].rise & en_rise[g]) | (evt[g].fall & en_fall[g]);
   end

   // Set is ORed in after the clear so a same-cycle collision leaves the bit pending.
   assign clr_mask = clr_valid ? clr[WIDTH_PIN-1:0] : '0;
   assign pend_nxt = (pend & ~clr_mask) | set;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_rise <= '0;
         en_fall <= '0;
         pend    <= '0;
         irq     <= 1'b0;
      end else begin
         if (cfg_valid) begin
            en_rise <= cfg_rise[WIDTH_PIN-1:0];
            en_fall <= cfg_fall[WIDTH_PIN-1:0];
         end
         pend <= pend_nxt;
         irq  <= |pend;
      end
   end

   assign level_o = gpio_bus_t'(level);
   assign pend_o  = gpio_bus_t'(pend);

   // Bus bits above WIDTH_PIN carry no meaning for this instance.
   assign unused_bus_bits = ^{cfg_rise, cfg_fall, clr};

endmodule
